// File: rtl/alu_pipe_pkg.sv
// Shared constants and stage-register layouts for the alu_pipe slice.
package alu_pipe_pkg;

   localparam int ALU_WIDTH     = 32;
   localparam int ALU_CNT_WIDTH = 16;
   // Upper bound on WIDTH. The stage structs are sized to it; an instance
   // only drives/uses the low WIDTH bits and synthesis trims the rest.
   localparam int ALU_MAX_W     = 64;

   // Stage 0: adder operands, already conditioned for add/subtract.
   typedef struct packed {
      logic [ALU_MAX_W-1:0] aa;
      logic [ALU_MAX_W-1:0] bb;
      logic                 ci;
   } alu_op_t;

   // Stage 1: registered result and flags.
   typedef struct packed {
      logic [ALU_MAX_W-1:0] sum;
      logic                 cout;
      logic                 zero;
      logic                 ovf;
   } alu_res_t;

endpackage

// File: rtl/alu_pipe_adder.sv
// Combinational Kogge-Stone prefix adder with carry-in.
module adder #(
   parameter int WIDTH = 32
) (
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             cin,
   output logic [WIDTH-1:0] sum,
   output logic             cout
);

   localparam int LVL = $clog2(WIDTH);

   logic [WIDTH-1:0] h;   // half-sum, kept for the final xor
   logic [WIDTH-1:0] g;   // group generate, bit i = carry out of bit i
   logic [WIDTH-1:0] p;   // group propagate

   assign h = a ^ b;

   // Prefix tree built in place; descending i keeps each level reading the
   // previous level's values. cin is folded into bit 0's generate so the
   // tree output is the true carry out of every bit.
   always_comb begin
      g    = a & b;
      g[0] = (a[0] & b[0]) | (h[0] & cin);
      p    = h;
      for (int k = 0; k < LVL; k++) begin
         for (int i = WIDTH - 1; i >= 0; i--) begin
            if (i >= (1 << k)) begin
               g[i] = g[i] | (p[i] & g[i - (1 << k)]);
               p[i] = p[i] & p[i - (1 << k)];
            end
         end
      end
   end

   assign sum  = h ^ {g[WIDTH-2:0], cin};
   assign cout = g[WIDTH-1];

endmodule

// File: rtl/alu_pipe.sv
// Two-stage valid/ready add/subtract pipeline around the prefix adder, with
// carry/zero/overflow flags and a completed-transaction counter.
module alu_pipe
   import alu_pipe_pkg::*;
#(
   parameter int WIDTH     = ALU_WIDTH,
   parameter int CNT_WIDTH = ALU_CNT_WIDTH
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 in_valid,
   output logic                 in_ready,
   input  logic [WIDTH-1:0]     in_a,
   input  logic [WIDTH-1:0]     in_b,
   input  logic                 in_sub,
   input  logic                 in_cin,
   output logic                 out_valid,
   input  logic                 out_ready,
   output logic [WIDTH-1:0]     out_sum,
   output logic                 out_cout,
   output logic                 out_zero,
   output logic                 out_ovf,
   output logic [CNT_WIDTH-1:0] done_cnt
);

   alu_op_t              op_d, op_q;
   alu_res_t             res_d, res_q;
   logic                 s0_v, s1_v;
   logic                 s1_ready;
   logic                 in_hs, out_hs, mv;
   logic [WIDTH-1:0]     sum_w;
   logic                 cout_w;
   logic [CNT_WIDTH-1:0] cnt_q;

   // Flow control: stage 1 frees when empty or draining; stage 0 frees when
   // empty or moving into stage 1. in_ready sees out_ready combinationally.
   assign s1_ready = !s1_v || out_ready;
   assign in_ready = !s0_v || s1_ready;
   assign in_hs    = in_valid && in_ready;
   assign out_hs   = s1_v && out_ready;
   assign mv       = s0_v && s1_ready;

   // Subtract is A + ~B + 1, so the conditioning happens before the flop.
   always_comb begin
      op_d    = '0;
      op_d.aa = ALU_MAX_W'(in_a);
      op_d.bb = ALU_MAX_W'(in_sub ? ~in_b : in_b);
      op_d.ci = in_sub ? 1'b1 : in_cin;
   end

   adder #(.WIDTH(WIDTH)) u_adder (
      .a    (op_q.aa[WIDTH-1:0]),
      .b    (op_q.bb[WIDTH-1:0]),
      .cin  (op_q.ci),
      .sum  (sum_w),
      .cout (cout_w)
   );

   // Flags derive from the conditioned operands, so overflow is correct for
   // both add and subtract.
   always_comb begin
      res_d      = '0;
      res_d.sum  = ALU_MAX_W'(sum_w);
      res_d.cout = cout_w;
      res_d.zero = ~|sum_w;
      res_d.ovf  = (op_q.aa[WIDTH-1] == op_q.bb[WIDTH-1]) &&
                   (sum_w[WIDTH-1] != op_q.aa[WIDTH-1]);
   end

   // Valid bits and counter: the only reset state.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         s0_v  <= 1'b0;
         s1_v  <= 1'b0;
         cnt_q <= '0;
      end else begin
         if (in_ready) s0_v <= in_valid;
         if (s1_ready) s1_v <= s0_v;
         if (out_hs)   cnt_q <= cnt_q + 1'b1;
      end
   end

   // Data registers load only on their handshakes and are never reset.
   always_ff @(posedge clk) begin
      if (in_hs) op_q  <= op_d;
      if (mv)    res_q <= res_d;
   end

   assign out_valid = s1_v;
   assign out_sum   = res_q.sum[WIDTH-1:0];
   assign out_cout  = res_q.cout;
   assign out_zero  = res_q.zero;
   assign out_ovf   = res_q.ovf;
   assign done_cnt  = cnt_q;

endmodule

// File: tb/tb_alu_pipe.sv
// Randomised and directed checks of alu_pipe against a beat-queue model.
module tb_alu_pipe;

   localparam int W  = 8;
   localparam int CW = 4;

   logic          clk = 1'b0;
   logic          rst_n;
   logic          in_valid, in_ready;
   logic [W-1:0]  in_a, in_b;
   logic          in_sub, in_cin;
   logic          out_valid, out_ready;
   logic [W-1:0]  out_sum;
   logic          out_cout, out_zero, out_ovf;
   logic [CW-1:0] done_cnt;

   alu_pipe #(.WIDTH(W), .CNT_WIDTH(CW)) dut (
      .clk(clk), .rst_n(rst_n),
      .in_valid(in_valid), .in_ready(in_ready),
      .in_a(in_a), .in_b(in_b), .in_sub(in_sub), .in_cin(in_cin),
      .out_valid(out_valid), .out_ready(out_ready),
      .out_sum(out_sum), .out_cout(out_cout), .out_zero(out_zero),
      .out_ovf(out_ovf), .done_cnt(done_cnt)
   );

   always #5 clk = ~clk;

   int            total = 0;
   int            bad   = 0;
   int            edges = 0;
   int            acc_cnt;
   logic [W+2:0]  rq[$];   // expected {sum, cout, zero, ovf} in order
   int            tq[$];   // edge at which each beat was accepted
   logic [CW-1:0] cnt_m;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Reference computed arithmetically: unsigned sums for carry/borrow,
   // signed integers for overflow.
   function automatic logic [W+2:0] model(input logic [W-1:0] a, input logic [W-1:0] b,
                                          input logic sub, input logic cin);
      int unsigned ua, ub, t;
      int          sa, sb, r;
      logic [W-1:0] s;
      logic        c, o;
      ua = a; ub = b;
      sa = $signed(a); sb = $signed(b);
      if (sub) begin
         t = (ua - ub) & ((1 << W) - 1);
         c = (ua >= ub);
         r = sa - sb;
      end else begin
         t = ua + ub + cin;
         c = (t >> W) & 1;
         r = sa + sb + int'(cin);
      end
      s = t[W-1:0];
      o = (r > (1 << (W - 1)) - 1) || (r < -(1 << (W - 1)));
      return {s, c, (s == '0), o};
   endfunction

   // One clock: drive, check against the model, then advance the model by
   // the handshakes the model predicts for this edge.
   task automatic cycle(input logic v, input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic sub, input logic cin, input logic ordy);
      logic exp_ir, exp_ov, ia, oa;
      in_valid = v; in_a = a; in_b = b; in_sub = sub; in_cin = cin; out_ready = ordy;
      #1;
      exp_ir = (rq.size() < 2) || ordy;
      exp_ov = (rq.size() > 0) && (edges - tq[0] >= 1);
      chk("in_ready", 32'(in_ready), 32'(exp_ir));
      chk("out_valid", 32'(out_valid), 32'(exp_ov));
      chk("done_cnt", 32'(done_cnt), 32'(cnt_m));
      if (exp_ov)
         chk("result", 32'({out_sum, out_cout, out_zero, out_ovf}), 32'(rq[0]));
      ia = v && exp_ir;
      oa = exp_ov && ordy;
      @(posedge clk);
      edges++;
      if (oa) begin
         void'(rq.pop_front());
         void'(tq.pop_front());
         cnt_m = cnt_m + 1'b1;
      end
      if (ia) begin
         rq.push_back(model(a, b, sub, cin));
         tq.push_back(edges);
         acc_cnt++;
      end
      @(negedge clk);
   endtask

   task automatic idle(input logic ordy);
      cycle(1'b0, '0, '0, 1'b0, 1'b0, ordy);
   endtask

   task automatic do_reset();
      rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
      @(posedge clk);
      edges++;
      @(negedge clk);
      #1;
      chk("rst out_valid", 32'(out_valid), 32'd0);
      chk("rst in_ready", 32'(in_ready), 32'd1);
      chk("rst done_cnt", 32'(done_cnt), 32'd0);
      rq.delete(); tq.delete(); cnt_m = '0;
      rst_n = 1'b1;
   endtask

   task automatic rnd_beat(input logic ordy);
      cycle(1'b1, W'($urandom), W'($urandom), 1'($urandom), 1'($urandom), ordy);
   endtask

   task automatic chk_out(input string tag, input logic [W-1:0] s, input logic c,
                          input logic z, input logic o);
      #1;
      chk({tag, " valid"}, 32'(out_valid), 32'd1);
      chk({tag, " sum"}, 32'(out_sum), 32'(s));
      chk({tag, " flags"}, 32'({out_cout, out_zero, out_ovf}), 32'({c, z, o}));
   endtask

   initial begin
      in_valid = 1'b0; in_a = '0; in_b = '0; in_sub = 1'b0; in_cin = 1'b0;
      out_ready = 1'b0; cnt_m = '0; acc_cnt = 0;
      rst_n = 1'b0;
      @(negedge clk);
      do_reset();

      // Directed add with signed overflow; visible the cycle after acceptance.
      cycle(1'b1, 8'h7F, 8'h01, 1'b0, 1'b0, 1'b1);
      idle(1'b0);
      chk_out("add7f", 8'h80, 1'b0, 1'b0, 1'b1);
      idle(1'b1);

      // Equal subtract: zero result, no borrow (cin ignored).
      cycle(1'b1, 8'h05, 8'h05, 1'b1, 1'b1, 1'b1);
      idle(1'b0);
      chk_out("sub55", 8'h00, 1'b1, 1'b1, 1'b0);
      idle(1'b1);

      // Borrow case.
      cycle(1'b1, 8'h00, 8'h01, 1'b1, 1'b0, 1'b1);
      idle(1'b0);
      chk_out("sub01", 8'hFF, 1'b0, 1'b0, 1'b0);
      idle(1'b1);
      idle(1'b1);

      // 100 back-to-back random beats, then drain.
      do_reset();
      acc_cnt = 0;
      for (int i = 0; i < 100; i++) rnd_beat(1'b1);
      chk("stream accepted", 32'(acc_cnt), 32'd100);
      idle(1'b1);
      idle(1'b1);
      chk("stream done_cnt", 32'(done_cnt), 32'(100 % (1 << CW)));
      chk("stream empty", 32'(out_valid), 32'd0);

      // Backpressure: exactly two beats fit, then drain in order.
      acc_cnt = 0;
      for (int i = 0; i < 5; i++) rnd_beat(1'b0);
      chk("stall accepted", 32'(acc_cnt), 32'd2);
      #1;
      chk("stall in_ready", 32'(in_ready), 32'd0);
      for (int i = 0; i < 3; i++) idle(1'b1);
      chk("stall drained", 32'(rq.size()), 32'd0);

      // Random mix of valid and ready.
      for (int i = 0; i < 60; i++)
         cycle(1'($urandom), W'($urandom), W'($urandom), 1'($urandom),
               1'($urandom), 1'($urandom));
      for (int i = 0; i < 3; i++) idle(1'b1);

      // Reset with two beats in flight; nothing stale afterwards.
      rnd_beat(1'b0);
      rnd_beat(1'b0);
      do_reset();
      for (int i = 0; i < 3; i++) idle(1'b1);

      // Counter wrap: 17 results on a 4-bit counter.
      do_reset();
      for (int i = 0; i < 17; i++) rnd_beat(1'b1);
      idle(1'b1);
      idle(1'b1);
      #1;
      chk("wrap done_cnt", 32'(done_cnt), 32'd1);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
